// File: rtl/store_buffer.sv
// Posted-write store buffer sitting on the cache->memory port.
// Stores are queued in program order and drained to memory whenever the port
// is granted and not claimed by an accepted read. A read whose word address
// matches any queued store is held off until that store has drained.
module store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [2:0]            funct3_i,
    input  logic                  mem_gnt_i,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  stall_o,
    output logic                  empty_o,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [2:0]            mem_funct3_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Queue storage: valid bits are reset, payload is not.
    logic [DEPTH-1:0]      valid_q;
    logic [ADDR_WIDTH-1:0] addr_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q   [DEPTH];
    logic [2:0]            funct3_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q;

    logic [DEPTH-1:0] match;
    logic             hit;
    logic             full;
    logic             rd_req;
    logic             rd_accept;
    logic             drain;
    logic             enq;

    // Word-granular address match against every live entry; access size is
    // deliberately ignored so overlapping sub-word accesses are always caught.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign match[gi] = valid_q[gi] &&
                               (addr_q[gi][ADDR_WIDTH-1:2] == addr_i[ADDR_WIDTH-1:2]);
        end
    endgenerate

    assign hit    = |match;
    assign full   = (count_q == CNT_W'(DEPTH));
    // A simultaneous read+store is illegal; it is handled as a plain store.
    assign rd_req = rd_en_i & ~wr_en_i;

    // The port is never used while reset is asserted, so nothing queued before
    // reset can leak to memory during the reset cycle.
    assign rd_accept = rd_req & ~hit & mem_gnt_i & rst_i;
    assign drain     = mem_gnt_i & ~rd_accept & (count_q != '0) & rst_i;
    // No full bypass: a store arriving while full waits even if a drain happens.
    assign enq       = wr_en_i & ~full;

    assign stall_o   = (wr_en_i & full) | (rd_req & (hit | ~mem_gnt_i));
    assign empty_o   = empty_q;
    assign rd_data_o = mem_rd_data_i;

    // Memory port mux: accepted read first, otherwise drain the head entry.
    always_comb begin
        mem_wr_en_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        mem_funct3_o = '0;
        if (rd_accept) begin
            mem_addr_o   = addr_i;
            mem_funct3_o = funct3_i;
        end else if (drain) begin
            mem_wr_en_o  = 1'b1;
            mem_addr_o   = addr_q[head_q];
            mem_data_o   = data_q[head_q];
            mem_funct3_o = funct3_q[head_q];
        end
    end

    // Next-state pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) begin
            head_d = head_q + PTR_W'(1);
        end
        if (enq) begin
            tail_d = tail_q + PTR_W'(1);
        end
        case ({enq, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: pointers, count, valid bits and the registered empty flag.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            // Enqueue and drain never target the same slot: that would need
            // head==tail with both a live head and a free tail.
            if (drain) begin
                valid_q[head_q] <= 1'b0;
            end
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
            end
        end
    end

    // Payload capture at the tail on every accepted store.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_q[tail_q]   <= addr_i;
            data_q[tail_q]   <= data_i;
            funct3_q[tail_q] <= funct3_i;
        end
    end

    // Read and store in the same cycle is a protocol violation upstream.
    assert property (@(posedge clk_i) disable iff (!rst_i) !(wr_en_i && rd_en_i));

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based reference model predicts
// memory writes and read acceptances; a monitor pops and compares them.
module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
    } wr_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  f3;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        wr_en_i, rd_en_i, mem_gnt_i;
    logic [31:0] addr_i, data_i, mem_rd_data_i;
    logic [2:0]  funct3_i;
    logic [31:0] rd_data_o, mem_addr_o, mem_data_o;
    logic        stall_o, empty_o, mem_wr_en_o;
    logic [2:0]  mem_funct3_o;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    bit exp_stall = 1'b0;

    wr_t model_q[$];
    wr_t wr_exp_q[$];
    rd_t rd_exp_q[$];

    store_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .rd_en_i(rd_en_i),
        .addr_i(addr_i), .data_i(data_i), .funct3_i(funct3_i),
        .mem_gnt_i(mem_gnt_i), .mem_rd_data_i(mem_rd_data_i),
        .rd_data_o(rd_data_o), .stall_o(stall_o), .empty_o(empty_o),
        .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_funct3_o(mem_funct3_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model updates from the pre-edge queue state.
    task automatic cyc(input bit rst, input bit w, input bit r, input bit g,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, input bit check);
        int  sz;
        bit  hit, full, rdeff, racc, exp_empty;
        wr_t e;
        rd_t q;
        @(posedge clk);
        #1;
        rst_i = ~rst; wr_en_i = w; rd_en_i = r; mem_gnt_i = g;
        addr_i = a; data_i = d; funct3_i = f; mem_rd_data_i = $urandom;
        sz = model_q.size();
        hit = 1'b0;
        foreach (model_q[i]) if (model_q[i].addr[31:2] == a[31:2]) hit = 1'b1;
        rdeff     = r && !w;
        full      = (sz == DEPTH);
        exp_stall = (w && full) || (rdeff && (hit || !g));
        exp_empty = (sz == 0);
        if (rst) begin
            model_q.delete();
        end else begin
            racc = rdeff && !hit && g;
            if (racc) begin
                q.addr = a; q.f3 = f;
                rd_exp_q.push_back(q);
            end
            if (g && !racc && sz > 0) wr_exp_q.push_back(model_q.pop_front());
            if (w && !full) begin
                e.addr = a; e.data = d; e.f3 = f;
                model_q.push_back(e);
            end
        end
        @(negedge clk);
        if (check) begin
            chk("stall", 32'(stall_o), 32'(exp_stall));
            chk("empty", 32'(empty_o), 32'(exp_empty));
        end
    endtask

    task automatic idle(input bit g, input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, g, 32'h0, 32'h0, 3'b0, 1);
    endtask

    // Monitor: compares every memory-port action against the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        rd_t q;
        bit  racc;
        if (mon_en) begin
            if (mem_wr_en_o === 1'b1) begin
                if (wr_exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(mem_wr_en_o), 32'h0);
                end else begin
                    e = wr_exp_q.pop_front();
                    chk("wr_addr", mem_addr_o, e.addr);
                    chk("wr_data", mem_data_o, e.data);
                    chk("wr_f3", 32'(mem_funct3_o), 32'(e.f3));
                end
            end else if (wr_exp_q.size() != 0) begin
                e = wr_exp_q.pop_front();
                chk("missing_write", 32'(mem_wr_en_o), 32'h1);
            end
            racc = rd_en_i && !wr_en_i && (stall_o === 1'b0) && (rst_i === 1'b1);
            if (racc) begin
                if (rd_exp_q.size() == 0) begin
                    chk("unexpected_read", 32'(stall_o), 32'h1);
                end else begin
                    q = rd_exp_q.pop_front();
                    chk("rd_addr", mem_addr_o, q.addr);
                    chk("rd_f3", 32'(mem_funct3_o), 32'(q.f3));
                    chk("rd_data", rd_data_o, mem_rd_data_i);
                end
            end else if (rd_exp_q.size() != 0) begin
                q = rd_exp_q.pop_front();
                chk("missing_read", 32'(stall_o), 32'h0);
            end
            if (mem_wr_en_o !== 1'b1 && !racc) begin
                chk("idle_addr", mem_addr_o, 32'h0);
                chk("idle_f3", 32'(mem_funct3_o), 32'h0);
            end
        end
    end

    initial begin
        bit          hw, hr;
        logic [31:0] ha, hd;
        logic [2:0]  hf;
        logic [2:0]  f3s [5];
        f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
        rst_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0; mem_gnt_i = 1'b0;
        addr_i = '0; data_i = '0; funct3_i = '0; mem_rd_data_i = '0;

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        mon_en = 1'b1;
        idle(0, 1);

        // Single sw drains one cycle later, then queue reports empty.
        cyc(0, 1, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 1);
        idle(1, 2);

        // Fill to DEPTH with grant low; fifth store stalls until space frees.
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 0, 0, 32'(i * 4), 32'hA000_0000 + 32'(i), 3'b010, 1);
        for (int k = 0; k < 8 && exp_stall; k++)
            cyc(0, 1, 0, 1, 32'h10, 32'hA000_0004, 3'b010, 1);
        idle(1, 6);

        // Reset with three entries queued: nothing may reach memory.
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 0, 0, 32'h100 + 32'(i * 4), 32'h5A5A_0000 + 32'(i), 3'b010, 1);
        cyc(1, 0, 0, 1, 0, 0, 0, 1);
        idle(1, 4);

        // Read hitting a queued store waits for the drain.
        cyc(0, 1, 0, 0, 32'h20, 32'h1111_2222, 3'b010, 1);
        cyc(0, 0, 1, 1, 32'h22, 0, 3'b001, 1);
        cyc(0, 0, 1, 1, 32'h22, 0, 3'b001, 1);

        // Non-matching read bypasses the queued store; drain resumes after.
        cyc(0, 1, 0, 0, 32'h40, 32'h3333_4444, 3'b010, 1);
        cyc(0, 0, 1, 1, 32'h80, 0, 3'b010, 1);
        idle(1, 2);

        // Read with no grant stalls until the grant arrives.
        cyc(0, 0, 1, 0, 32'h80, 0, 3'b010, 1);
        cyc(0, 0, 1, 1, 32'h80, 0, 3'b010, 1);

        // Random traffic; a stalled request is held unchanged as upstream would.
        hw = 0; hr = 0; ha = 0; hd = 0; hf = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!exp_stall) begin
                int sel;
                sel = $urandom_range(0, 9);
                hw = (sel < 4);
                hr = (sel >= 4 && sel < 7);
                ha = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                hd = $urandom;
                hf = f3s[$urandom_range(0, 4)];
            end
            if ($urandom_range(0, 499) == 0) begin
                cyc(1, 0, 0, 1, 0, 0, 0, 1);
                exp_stall = 1'b0;
            end else begin
                cyc(0, hw, hr, ($urandom_range(0, 9) < 6), ha, hd, hf, 1);
            end
        end
        idle(1, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
